// File: rtl/cache_fill_ctrl.sv
// Miss-handling sequencer: streams 8 pipelined word reads for one cache block and then writes the tag.
// Optional watchdog abort is compiled in with FILL_TIMEOUT_EN.
module cache_fill_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int BLOCK_WORDS    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [2:0]            fill_offset,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic                  fsm_busy,
    output logic                  fill_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TAGWR = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-5:0] blk_base_q, blk_base_d;
    logic [3:0]            issue_cnt_q, issue_cnt_d;
    logic [3:0]            rx_cnt_q, rx_cnt_d;

`ifdef FILL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // The low nibble of the miss address only selects a word inside the block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_address[3:0];

    assign memory_address = {blk_base_q, issue_cnt_q[2:0], 1'b0};
    assign fill_offset    = rx_cnt_q[2:0];

    always_comb begin
        state_d          = state_q;
        blk_base_d       = blk_base_q;
        issue_cnt_d      = issue_cnt_q;
        rx_cnt_d         = rx_cnt_q;
        mem_rd_en        = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fsm_busy         = 1'b0;
        fill_error       = 1'b0;
`ifdef FILL_TIMEOUT_EN
        wait_cnt_d       = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    blk_base_d  = miss_address[ADDR_WIDTH-1:4];
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
`ifdef FILL_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                    state_d     = FILL;
                end
            end
            FILL: begin
                fsm_busy  = 1'b1;
                mem_rd_en = (issue_cnt_q < 4'(BLOCK_WORDS));
                if (mem_rd_en) begin
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                // Responses return in request order, so rx_cnt is the offset of this word.
                write_data_array = memory_data_valid;
                if (memory_data_valid) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'(BLOCK_WORDS - 1)) begin
                        state_d = TAGWR;
                    end
                end
`ifdef FILL_TIMEOUT_EN
                wait_cnt_d = memory_data_valid ? '0 : wait_cnt_q + 1'b1;
                if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES)) begin
                    fill_error       = 1'b1;
                    write_data_array = 1'b0;
                    issue_cnt_d      = '0;
                    rx_cnt_d         = '0;
                    wait_cnt_d       = '0;
                    state_d          = IDLE;
                end
`endif
            end
            TAGWR: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            blk_base_q  <= '0;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            blk_base_q  <= blk_base_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

`ifdef FILL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: cycle n is the clock period after edge n-1, edge 0 samples the miss.
// The watchdog scenario is compiled in with FILL_TIMEOUT_EN.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        mem_rd_en;
    logic [15:0] memory_address;
    logic [2:0]  fill_offset;
    logic        write_data_array;
    logic        write_tag_array;
    logic        fsm_busy;
    logic        fill_error;

    int n_tests;
    int n_fail;
    logic [2:0] exp_q[$];

    cache_fill_ctrl #(
        .ADDR_WIDTH    (16),
        .BLOCK_WORDS   (8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .mem_rd_en        (mem_rd_en),
        .memory_address   (memory_address),
        .fill_offset      (fill_offset),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .fsm_busy         (fsm_busy),
        .fill_error       (fill_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},   32'(mem_rd_en),        32'd0);
        check({tag, "_addr"}, 32'(memory_address),   32'd0);
        check({tag, "_off"},  32'(fill_offset),      32'd0);
        check({tag, "_wr"},   32'(write_data_array), 32'd0);
        check({tag, "_tag"},  32'(write_tag_array),  32'd0);
        check({tag, "_busy"}, 32'(fsm_busy),         32'd0);
        check({tag, "_err"},  32'(fill_error),       32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a miss so that the next rising edge (edge 0) samples it; returns in cycle 1.
    task automatic start_miss(input logic [15:0] addr);
        miss_detected = 1'b1;
        miss_address  = addr;
        next_cycle();
        miss_detected = 1'b0;
    endtask

    // Latency-1 fill: valids in cycles 2..9, tag write expected in cycle 10.
    task automatic simple_fill(input string tag, input logic [15:0] base);
        for (int c = 1; c <= 11; c++) begin
            memory_data_valid = (c >= 2 && c <= 9);
            @(negedge clk);
            if (c == 1) check({tag, "_addr_first"}, 32'(memory_address), 32'(base));
            if (c == 8) check({tag, "_addr_last"},  32'(memory_address), 32'(base + 16'd14));
            if (c == 10) check({tag, "_tag"}, 32'(write_tag_array), 32'd1);
            if (c == 11) check({tag, "_idle"}, 32'(fsm_busy), 32'd0);
            next_cycle();
        end
        memory_data_valid = 1'b0;
    endtask

    initial begin
        int n_wr;
        int n_tag;
        int tag_cyc;
        n_tests           = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data_valid = 1'b0;

        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();

        // Latency 4 fill from 0x1236.
        start_miss(16'h1236);
        for (int c = 1; c <= 15; c++) begin
            memory_data_valid = (c >= 5 && c <= 12);
            @(negedge clk);
            check("l4_rd", 32'(mem_rd_en), 32'(c <= 8));
            if (c <= 8) check("l4_addr", 32'(memory_address), 32'(16'h1230 + 16'(2 * (c - 1))));
            check("l4_wr", 32'(write_data_array), 32'(c >= 5 && c <= 12));
            if (c >= 5 && c <= 12) check("l4_off", 32'(fill_offset), 32'(c - 5));
            check("l4_tag", 32'(write_tag_array), 32'(c == 13));
            check("l4_busy", 32'(fsm_busy), 32'(c <= 13));
            check("l4_err", 32'(fill_error), 32'd0);
            next_cycle();
        end
        memory_data_valid = 1'b0;

        // Latency 1, valid on two of every three cycles.
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(3'(k));
        n_wr    = 0;
        n_tag   = 0;
        tag_cyc = 0;
        start_miss(16'h5A5A);
        for (int c = 1; c <= 16; c++) begin
            memory_data_valid = (c >= 2 && c <= 12 && ((c - 2) % 3) != 2);
            @(negedge clk);
            if (write_data_array) begin
                n_wr++;
                if (exp_q.size() == 0) check("gap_extra_wr", 32'd1, 32'd0);
                else check("gap_off", 32'(fill_offset), 32'(exp_q.pop_front()));
            end
            if (write_tag_array) begin
                n_tag++;
                tag_cyc = c;
            end
            next_cycle();
        end
        memory_data_valid = 1'b0;
        check("gap_n_wr", 32'(n_wr), 32'd8);
        check("gap_n_tag", 32'(n_tag), 32'd1);
        check("gap_tag_cyc", 32'(tag_cyc), 32'd13);
        check("gap_left", 32'(exp_q.size()), 32'd0);

        // Miss during FILL/TAGWR is ignored; re-presented in the IDLE cycle it starts a new fill.
        start_miss(16'h2000);
        for (int c = 1; c <= 11; c++) begin
            memory_data_valid = (c >= 2 && c <= 9);
            miss_detected     = (c >= 3);
            miss_address      = 16'h0040;
            @(negedge clk);
            if (c == 5) check("busy_miss_addr", 32'(memory_address), 32'h2008);
            if (c == 9) check("busy_miss_off", 32'(fill_offset), 32'd7);
            if (c == 10) check("busy_miss_tag", 32'(write_tag_array), 32'd1);
            if (c == 11) check("busy_miss_idle", 32'(fsm_busy), 32'd0);
            next_cycle();
        end
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;

        // New fill from 0x0040; reset after three returned words.
        for (int f = 1; f <= 4; f++) begin
            memory_data_valid = (f >= 2);
            @(negedge clk);
            if (f == 1) begin
                check("refill_rd", 32'(mem_rd_en), 32'd1);
                check("refill_addr", 32'(memory_address), 32'h0040);
            end else begin
                check("refill_off", 32'(fill_offset), 32'(f - 2));
            end
            next_cycle();
        end
        memory_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        next_cycle();
        rst_n = 1'b1;

        // Stray responses in IDLE, no miss.
        for (int c = 0; c < 4; c++) begin
            memory_data_valid = 1'b1;
            @(negedge clk);
            check_all_zero("idle_valid");
            next_cycle();
        end
        memory_data_valid = 1'b0;

        // Top-of-address-space block still fills normally.
        start_miss(16'hFFFE);
        simple_fill("top", 16'hFFF0);

`ifdef FILL_TIMEOUT_EN
        // Memory stops after word 5 (last valid cycle 6): abort pulse in cycle 71.
        n_tag = 0;
        start_miss(16'h3000);
        for (int c = 1; c <= 74; c++) begin
            memory_data_valid = (c >= 2 && c <= 6);
            @(negedge clk);
            if (write_tag_array) n_tag++;
            check("to_err", 32'(fill_error), 32'(c == 71));
            if (c == 70) check("to_busy_pre", 32'(fsm_busy), 32'd1);
            if (c == 72) check("to_idle", 32'(fsm_busy), 32'd0);
            next_cycle();
        end
        memory_data_valid = 1'b0;
        check("to_n_tag", 32'(n_tag), 32'd0);
        start_miss(16'h4444);
        simple_fill("after_to", 16'h4440);
`else
        // Without the watchdog, a stalled fill just waits.
        start_miss(16'h3000);
        for (int c = 1; c <= 90; c++) begin
            memory_data_valid = (c >= 2 && c <= 6);
            @(negedge clk);
            if (c == 80) begin
                check("wait_busy", 32'(fsm_busy), 32'd1);
                check("wait_err", 32'(fill_error), 32'd0);
                check("wait_off", 32'(fill_offset), 32'd5);
            end
            next_cycle();
        end
        memory_data_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
